stream_demux1to2: RTL
=====================

Name: stream_demux1to2

Overview:
- Registered 1-to-2 stream demultiplexer; the return-path counterpart of mux2to1.
- Routes one valid/ready input stream to one of two output streams, chosen per beat by a select bit.
- Each output has a one-entry holding register, so outputs are fully registered with full throughput.
- Sits wherever a shared bus must fan back out to two consumers.

Parameters:
- width, 8, data width in bits of the input and both outputs.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  width  input beat payload.
- in_sel  input  1  destination of the beat: 0 routes to out0, 1 routes to out1.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- out0_data  output  width  out0 payload.
- out0_valid  output  1  out0 beat present.
- out0_ready  input  1  out0 consumer accepts.
- out1_data  output  width  out1 payload.
- out1_valid  output  1  out1 beat present.
- out1_ready  input  1  out1 consumer accepts.

Behaviour:
- Reset: rst_n low clears immediately, independent of clk.
  - out0_valid = out1_valid = 0.
  - out0_data = out1_data = 0.
  - Any held beat is discarded.
  - in_ready follows its equation; it evaluates to 1 in reset because both slots are EMPTY.
- Per-output slot state machine, states EMPTY and FULL; outN_valid = (state == FULL).
  - EMPTY -> FULL on load (accepted beat with in_sel = N).
  - FULL -> EMPTY on drain (outN_valid && outN_ready) with no load.
  - FULL stays FULL on simultaneous drain and load; the register takes the new beat.
  - FULL stays FULL on no drain; data is held stable.
- in_ready = (in_sel ? (!out1_valid || out1_ready) : (!out0_valid || out0_ready)).
  - in_ready is combinational from in_sel and the selected port's ready.
  - in_ready is independent of in_valid.
- Accept = in_valid && in_ready. On accept, in_data is registered into the selected slot at the next clk edge.
- The non-selected slot is never written by an accepted beat.
- Latency: a beat accepted at edge k is visible on outN at edge k+1 (one cycle).
- Throughput: one beat per cycle when the selected consumer holds ready high.
- Data stability: while outN_valid && !outN_ready, outN_data and outN_valid do not change.
- outN_valid never depends combinationally on outN_ready.
- Ordering:
  - Per-output order is preserved.
  - No ordering relation exists between out0 and out1.
- Head-of-line: a stalled port blocks only when the current input beat targets it. A beat for the other port passes if that slot is free or draining.
- in_valid low: no load; slots drain normally.
- in_sel may change freely while in_valid is low. While in_valid && !in_ready, the upstream holds in_data and in_sel stable per protocol.
- Reset asserted mid-transfer: held beats are lost, no partial output, valid drops in the same cycle.

Optional Feature:
- Macro: STREAM_DEMUX_COUNT_EN.
- Defined:
  - Adds output ports out0_count and out1_count, 16 bits each.
  - Each counter increments by 1 on every drain of its port.
  - Counters wrap from 65535 to 0.
  - Counters reset to 0 asynchronously with rst_n.
- Not defined:
  - Ports and counter logic are absent.
  - Datapath behaviour is identical in both builds.

Test Plan:
- Reset values: rst_n=0 with in_valid=1 -> out0_valid=out1_valid=0, out0_data=out1_data=0, in_ready=1. Release rst_n -> outputs stay idle until the first accept.
- Basic route: in_data=78, in_sel=0, in_valid=1 for one cycle, both readys=1 -> next cycle out0_valid=1, out0_data=78, out1_valid=0. Then in_data=150, in_sel=1 -> out1_data=150 one cycle later.
- Backpressure hold: load 200 to out0 with out0_ready=0 -> out0_data=200, valid held for 5 cycles. A second beat to out0 sees in_ready=0. Raise out0_ready -> 200 drains, second beat loads in the same edge.
- Bypass of stalled port: out0 FULL with out0_ready=0, send in_data=2, in_sel=1 -> in_ready=1, out1_data=2 next cycle, out0 unchanged.
- Streaming: 8 back-to-back beats 1..8 alternating sel, both readys=1 -> every cycle accepted. out0 sees 1,3,5,7 and out1 sees 2,4,6,8, each one cycle after acceptance.
- Async reset mid-stream: assert rst_n low between clk edges while out1 holds 150 -> out1_valid=0 immediately. With STREAM_DEMUX_COUNT_EN, drive 65537 out0 drains -> out0_count=1.

Source files
------------

// File: rtl/stream_demux1to2_if.sv
// Valid/ready bundle for the 1-to-2 stream demux: one input stream, two output streams.
// The slave modport is the demux's view; the master modport is the upstream/downstream side.
interface stream_demux1to2_if #(
  parameter int width = 8
);
  logic [width-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [width-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;

  modport slave (
    input  in_data, in_sel, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid
  );

  modport master (
    output in_data, in_sel, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid
  );
endinterface

// File: rtl/stream_demux1to2.sv
// Registered 1-to-2 stream demux; each output has a one-entry EMPTY/FULL holding slot.
// Optional STREAM_DEMUX_COUNT_EN adds 16-bit per-port drain counters.
module stream_demux1to2 #(
  parameter int width = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  stream_demux1to2_if.slave      bus
`ifdef STREAM_DEMUX_COUNT_EN
  ,
  output logic [15:0]            out0_count,
  output logic [15:0]            out1_count
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_e;

  slot_state_e      state_q [2];
  slot_state_e      state_d [2];
  logic [width-1:0] data_q  [2];
  logic [width-1:0] data_d  [2];

  logic [1:0] out_ready;
  logic [1:0] slot_free;
  logic [1:0] load;
  logic [1:0] drain;
  logic       accept;

  assign out_ready = {bus.out1_ready, bus.out0_ready};

  // A slot can take a beat when it is empty or its current beat drains this cycle.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    slot_free = '0;
    load      = '0;
    drain     = '0;
    for (int n = 0; n < 2; n++) begin
      slot_free[n] = (state_q[n] == EMPTY) || out_ready[n];
      drain[n]     = (state_q[n] == FULL) && out_ready[n];
    end
    bus.in_ready = bus.in_sel ? slot_free[1] : slot_free[0];
    accept       = bus.in_valid && bus.in_ready;
    load[0]      = accept && !bus.in_sel;
    load[1]      = accept &&  bus.in_sel;
  end

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      state_d[n] = state_q[n];
      data_d[n]  = data_q[n];
      case (state_q[n])
        EMPTY: begin
          if (load[n]) begin
            state_d[n] = FULL;
            data_d[n]  = bus.in_data;
          end
        end
        FULL: begin
          if (load[n]) begin
            data_d[n] = bus.in_data;
          end else if (drain[n]) begin
            state_d[n] = EMPTY;
          end
        end
        default: state_d[n] = EMPTY;
      endcase
    end
  end

  // NOTE: the holding registers are reset along with the state, so outputs read 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 2; n++) begin
        state_q[n] <= EMPTY;
        data_q[n]  <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      for (int n = 0; n < 2; n++) begin
        state_q[n] <= state_d[n];
        data_q[n]  <= data_d[n];
      end
    end
  end

  assign bus.out0_valid = (state_q[0] == FULL);
  assign bus.out1_valid = (state_q[1] == FULL);
  assign bus.out0_data  = data_q[0];
  assign bus.out1_data  = data_q[1];

`ifdef STREAM_DEMUX_COUNT_EN
  logic [15:0] count_q [2];
  logic [15:0] count_d [2];

  // Free-running drain counters; natural 16-bit overflow gives the wrap to 0.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      count_d[n] = drain[n] ? count_q[n] + 16'd1 : count_q[n];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 2; n++) count_q[n] <= '0;
    end else begin
      for (int n = 0; n < 2; n++) count_q[n] <= count_d[n];
    end
  end

  assign out0_count = count_q[0];
  assign out1_count = count_q[1];
`endif

endmodule
